sn74hc165_reader: RTL and testbench

Serial input scanner for a chain of SN74HC165 parallel-in/serial-out shift registers carrying the board's key and switch bank. It is the input-side counterpart of the SN74HC595 LED output driver: it pulses the load line, clocks the chain out bit by bit, and samples the serial data. Each completed scan is presented as a parallel word, with a one-cycle valid strobe and per-bit falling-edge pulses for the key-press logic in `top`.

---
 rtl/traffic_pkg.sv | 17 +
 rtl/sn74hc165_debounce.sv | 47 ++++
 rtl/sn74hc165_reader.sv | 157 +++++++++++++++
 tb/tb_sn74hc165_reader.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared constants and the SN74HC165 scanner state encoding.
package traffic_pkg;

    localparam int SCAN_GAP_DEFAULT = 1200;
    localparam int DEB_CNT_DEFAULT  = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_SETTLE   = 3'd2,
        ST_SHIFT_LO = 3'd3,
        ST_SHIFT_HI = 3'd4,
        ST_DONE     = 3'd5,
        ST_GAP      = 3'd6
    } hc165_state_e;

endpackage

// File: rtl/sn74hc165_debounce.sv
// Scan-level debounce: a word is accepted once DEB_CNT consecutive scans agree.
module sn74hc165_debounce #(
    parameter int WIDTH   = 8,
    parameter int DEB_CNT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             scan_valid_i,
    input  logic [WIDTH-1:0] scan_word_i,
    output logic             accept_o,
    output logic [WIDTH-1:0] accept_word_o
);

    localparam int CW = $clog2(DEB_CNT + 1);
    localparam logic [CW-1:0] DEB_MAX = CW'(DEB_CNT);

    logic [WIDTH-1:0] cand_q, cand_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (scan_valid_i) begin
            if (scan_word_i == cand_q) begin
                cnt_d = (cnt_q == DEB_MAX) ? cnt_q : cnt_q + 1'b1;
            end else begin
                cand_d = scan_word_i;
                cnt_d  = CW'(1);
            end
        end
    end

    // Decision uses the updated count so the DEB_CNT-th agreeing scan is accepted.
    assign accept_o      = scan_valid_i && (cnt_d == DEB_MAX);
    assign accept_word_o = cand_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_q <= '1;
            cnt_q  <= '0;
        end else begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/sn74hc165_reader.sv
// Scanner for a chain of SN74HC165 shift registers; loads, clocks out and latches the word.
// Optional scan debounce is compiled in with `define SN74HC165_DEBOUNCE_EN.
module sn74hc165_reader
    import traffic_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CLK_DIV  = 6,
    parameter int SCAN_GAP = SCAN_GAP_DEFAULT,
    parameter int DEB_CNT  = DEB_CNT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_enable,
    input  logic             SN74HC165_data,
    output logic             SN74HC165_data_clk,
    output logic             SN74HC165_load_n,
    output logic [WIDTH-1:0] o_buf,
    output logic             o_valid,
    output logic             o_change,
    output logic [WIDTH-1:0] o_fall_pulse,
    output hc165_state_e     o_state
);

    localparam int PMAX = (CLK_DIV > SCAN_GAP) ? CLK_DIV : SCAN_GAP;
    localparam int PW   = $clog2(PMAX) + 1;
    localparam int BW   = $clog2(WIDTH) + 1;
    localparam logic [PW-1:0] DIV_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] GAP_LAST = PW'((SCAN_GAP > 0) ? SCAN_GAP - 1 : 0);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    hc165_state_e     state_q, state_d;
    logic [PW-1:0]    cnt_q, cnt_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             data_clk_q, load_n_q, valid_q, change_q;
    logic [WIDTH-1:0] buf_q, fall_q;
    logic             phase_end;
    logic             done_w, accept_w;
    logic [WIDTH-1:0] acc_word_w;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_d     = bit_q;
        shift_d   = shift_q;
        phase_end = (cnt_q == DIV_LAST);
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (i_enable) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (phase_end) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end
            end
            ST_SETTLE: begin
                if (phase_end) begin
                    state_d = ST_SHIFT_LO;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            ST_SHIFT_LO: begin
                if (phase_end) begin
                    shift_d = (shift_q << 1) | WIDTH'(SN74HC165_data);
                    state_d = ST_SHIFT_HI;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT_HI: begin
                if (phase_end) begin
                    cnt_d   = '0;
                    bit_d   = bit_q + 1'b1;
                    state_d = (bit_q == BIT_LAST) ? ST_DONE : ST_SHIFT_LO;
                end
            end
            ST_DONE: begin
                cnt_d = '0;
                // With no gap the next scan starts straight away.
                if (SCAN_GAP == 0) state_d = i_enable ? ST_LOAD : ST_IDLE;
                else               state_d = ST_GAP;
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = i_enable ? ST_LOAD : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign done_w = (state_q == ST_DONE);

`ifdef SN74HC165_DEBOUNCE_EN
    sn74hc165_debounce #(
        .WIDTH   (WIDTH),
        .DEB_CNT (DEB_CNT)
    ) u_debounce (
        .clk           (clk),
        .rst_n         (rst_n),
        .scan_valid_i  (done_w),
        .scan_word_i   (shift_q),
        .accept_o      (accept_w),
        .accept_word_o (acc_word_w)
    );
`else
    // DEB_CNT has no effect without debounce; the term is always true.
    assign accept_w   = done_w && (DEB_CNT >= 0);
    assign acc_word_w = shift_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            data_clk_q <= 1'b0;
            load_n_q   <= 1'b1;
            buf_q      <= '1;
            valid_q    <= 1'b0;
            change_q   <= 1'b0;
            fall_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            // Pins follow the next state so they line up with state_q.
            data_clk_q <= (state_d == ST_SHIFT_HI);
            load_n_q   <= (state_d != ST_LOAD);
            valid_q    <= done_w;
            change_q   <= 1'b0;
            fall_q     <= '0;
            if (accept_w) begin
                buf_q    <= acc_word_w;
                change_q <= (acc_word_w != buf_q);
                fall_q   <= buf_q & ~acc_word_w;
            end
        end
    end

    assign SN74HC165_data_clk = data_clk_q;
    assign SN74HC165_load_n   = load_n_q;
    assign o_buf              = buf_q;
    assign o_valid            = valid_q;
    assign o_change           = change_q;
    assign o_fall_pulse       = fall_q;
    assign o_state            = state_q;

endmodule

// File: tb/tb_sn74hc165_reader.sv
// Directed bench for sn74hc165_reader: an 8-bit chain (gap 20) and a 1-bit chain (gap 0).
module tb_sn74hc165_reader;
    import traffic_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- instance A: WIDTH 8, CLK_DIV 6, SCAN_GAP 20
    logic       en_a, data_a, dclk_a, load_a, valid_a, change_a;
    logic [7:0] buf_a, fall_a, pat_a, sr_a;
    logic [2:0] st_a;

    sn74hc165_reader #(.WIDTH(8), .CLK_DIV(6), .SCAN_GAP(20), .DEB_CNT(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .i_enable(en_a), .SN74HC165_data(data_a),
        .SN74HC165_data_clk(dclk_a), .SN74HC165_load_n(load_a), .o_buf(buf_a),
        .o_valid(valid_a), .o_change(change_a), .o_fall_pulse(fall_a), .o_state(st_a)
    );

    always @(posedge dclk_a or negedge load_a)
        if (!load_a) sr_a <= pat_a;
        else         sr_a <= {sr_a[6:0], 1'b1};
    assign data_a = sr_a[7];

    // ---------------- instance B: WIDTH 1, CLK_DIV 6, SCAN_GAP 0
    logic       en_b, data_b, dclk_b, load_b, valid_b, change_b, bit_b;
    logic [0:0] buf_b, fall_b;
    logic [7:0] sr_b;
    logic [2:0] st_b;

    sn74hc165_reader #(.WIDTH(1), .CLK_DIV(6), .SCAN_GAP(0), .DEB_CNT(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .i_enable(en_b), .SN74HC165_data(data_b),
        .SN74HC165_data_clk(dclk_b), .SN74HC165_load_n(load_b), .o_buf(buf_b),
        .o_valid(valid_b), .o_change(change_b), .o_fall_pulse(fall_b), .o_state(st_b)
    );

    always @(posedge dclk_b or negedge load_b)
        if (!load_b) sr_b <= {bit_b, 7'h7F};
        else         sr_b <= {sr_b[6:0], 1'b1};
    assign data_b = sr_b[7];

    // ---------------- scan vectors for instance A: pattern, expected buf/change/fall
    logic [7:0] v_pat [11] = '{8'hA5, 8'hA5, 8'hA5, 8'hFE, 8'hFF, 8'hFE, 8'hFF, 8'hFE, 8'hFE, 8'hFE, 8'hFE};
`ifdef SN74HC165_DEBOUNCE_EN
    logic [7:0] v_buf [11] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFE};
    logic       v_chg [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    logic [7:0] v_fal [11] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
`else
    logic [7:0] v_buf [11] = '{8'hA5, 8'hA5, 8'hA5, 8'hFE, 8'hFF, 8'hFE, 8'hFF, 8'hFE, 8'hFE, 8'hFE, 8'hFE};
    logic       v_chg [11] = '{1, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0};
    logic [7:0] v_fal [11] = '{8'h5A, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
`endif

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic wait_valid_a(output bit ok, output int t);
        ok = 1'b0;
        t  = 0;
        for (int i = 0; i < 600 && !ok; i++) begin
            @(negedge clk);
            if (valid_a) begin
                ok = 1'b1;
                t  = cyc;
            end
        end
    endtask

    task automatic wait_valid_b(output bit ok, output int t);
        ok = 1'b0;
        t  = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (valid_b) begin
                ok = 1'b1;
                t  = cyc;
            end
        end
    endtask

    task automatic wait_state_a(input logic [2:0] s, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 600 && !ok; i++) begin
            @(negedge clk);
            if (st_a == s) ok = 1'b1;
        end
    endtask

    initial begin
        bit   ok, got, prev;
        int   t0, tv, tprev, lo_cnt, rises;

        rst_n = 1'b0;
        en_a  = 1'b0;
        en_b  = 1'b0;
        pat_a = 8'hA5;
        bit_b = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_buf",   32'(buf_a),    32'hFF);
        check("rst_valid", 32'(valid_a),  32'h0);
        check("rst_change",32'(change_a), 32'h0);
        check("rst_fall",  32'(fall_a),   32'h0);
        check("rst_load_n",32'(load_a),   32'h1);
        check("rst_dclk",  32'(dclk_a),   32'h0);
        check("rst_state", 32'(st_a),     32'(ST_IDLE));
        rst_n = 1'b1;

        // First scan: load width, data clock count, latency from LOAD entry.
        @(negedge clk);
        en_a   = 1'b1;
        lo_cnt = 0;
        rises  = 0;
        t0     = -1;
        tv     = 0;
        got    = 1'b0;
        prev   = dclk_a;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (!load_a) begin
                lo_cnt++;
                if (t0 < 0) t0 = cyc;
            end
            if (dclk_a && !prev) rises++;
            prev = dclk_a;
            if (valid_a) begin
                got = 1'b1;
                tv  = cyc;
            end
        end
        check("scan1_seen",    32'(got),     32'h1);
        check("scan1_load_lo", 32'(lo_cnt),  32'd6);
        check("scan1_rises",   32'(rises),   32'd8);
        check("scan1_latency", 32'(tv - t0), 32'd109);
        check("scan1_buf",     32'(buf_a),    32'(v_buf[0]));
        check("scan1_change",  32'(change_a), 32'(v_chg[0]));
        check("scan1_fall",    32'(fall_a),   32'(v_fal[0]));
        @(negedge clk);
        check("valid_one_cycle", 32'(valid_a), 32'h0);
        check("fall_one_cycle",  32'(fall_a),  32'h0);

        // Remaining scans: the next pattern is applied during the gap.
        tprev = tv;
        for (int k = 1; k < 11; k++) begin
            pat_a = v_pat[k];
            wait_valid_a(ok, tv);
            check($sformatf("scan%0d_seen", k + 1),   32'(ok),         32'h1);
            check($sformatf("scan%0d_period", k + 1), 32'(tv - tprev), 32'd129);
            check($sformatf("scan%0d_buf", k + 1),    32'(buf_a),      32'(v_buf[k]));
            check($sformatf("scan%0d_change", k + 1), 32'(change_a),   32'(v_chg[k]));
            check($sformatf("scan%0d_fall", k + 1),   32'(fall_a),     32'(v_fal[k]));
            tprev = tv;
        end

        // Enable drops mid-scan: the scan still completes, then the FSM parks.
        wait_state_a(3'(ST_SHIFT_LO), ok);
        check("drop_reach_shift", 32'(ok), 32'h1);
        en_a = 1'b0;
        wait_valid_a(ok, tv);
        check("drop_valid",  32'(ok),       32'h1);
        check("drop_buf",    32'(buf_a),    32'hFE);
        check("drop_change", 32'(change_a), 32'h0);
        repeat (25) @(negedge clk);
        check("drop_idle",   32'(st_a),   32'(ST_IDLE));
        check("drop_load_n", 32'(load_a), 32'h1);
        rises  = 0;
        lo_cnt = 0;
        prev   = dclk_a;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (dclk_a && !prev) rises++;
            if (!load_a) lo_cnt++;
            prev = dclk_a;
        end
        check("drop_no_dclk", 32'(rises),  32'd0);
        check("drop_no_load", 32'(lo_cnt), 32'd0);

        // Reset asserted while the data clock is high.
        en_a = 1'b1;
        wait_state_a(3'(ST_SHIFT_HI), ok);
        check("mid_reach_hi", 32'(ok),     32'h1);
        check("mid_dclk_hi",  32'(dclk_a), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_dclk",  32'(dclk_a),  32'h0);
        check("mid_rst_load",  32'(load_a),  32'h1);
        check("mid_rst_buf",   32'(buf_a),   32'hFF);
        check("mid_rst_valid", 32'(valid_a), 32'h0);
        check("mid_rst_state", 32'(st_a),    32'(ST_IDLE));
        en_a = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (valid_a) got = 1'b1;
        end
        check("mid_rst_no_valid", 32'(got), 32'h0);

        // One-bit chain with no gap: back-to-back scans every 25 cycles.
        en_b = 1'b1;
        wait_valid_b(ok, tv);
        check("w1_seen1",   32'(ok),       32'h1);
        check("w1_buf1",    32'(buf_b),    32'h0);
        check("w1_change1", 32'(change_b), 32'h1);
        check("w1_fall1",   32'(fall_b),   32'h1);
        tprev = tv;
        wait_valid_b(ok, tv);
        check("w1_period2", 32'(tv - tprev), 32'd25);
        check("w1_buf2",    32'(buf_b),      32'h0);
        check("w1_fall2",   32'(fall_b),     32'h0);
        check("w1_change2", 32'(change_b),   32'h0);
        bit_b = 1'b1;
        tprev = tv;
        wait_valid_b(ok, tv);
        check("w1_period3", 32'(tv - tprev), 32'd25);
        wait_valid_b(ok, tv);
        check("w1_buf4",    32'(buf_b),    32'h1);
        check("w1_change4", 32'(change_b), 32'h1);
        check("w1_fall4",   32'(fall_b),   32'h0);
        en_b = 1'b0;
        repeat (30) @(negedge clk);
        check("w1_idle", 32'(st_b), 32'(ST_IDLE));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
